// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: TX/RX byte FIFOs, DATA/STATUS/CTRL registers and a level irq.
// Define UART_LOOPBACK_EN to build the CTRL[2] loopback path from the TX sequencer into the RX FIFO.
module uart_mmio_ctrl #(
    parameter int          TX_DEPTH  = 8,
    parameter int          RX_DEPTH  = 8,
    parameter logic [63:0] BASE_ADDR = 64'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] bus_addr,
    input  logic        bus_wen,
    input  logic        bus_ren,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_break,
    output logic        irq
);
    localparam int TXW = $clog2(TX_DEPTH);
    localparam int RXW = $clog2(RX_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} txState_e;

    txState_e     state_q;
    logic [7:0]   txData_q;
    logic         txEn_q;
    logic [1:0]   waitCnt_q;

    logic [7:0]   txMem [TX_DEPTH];
    logic [TXW:0] txWptr_q, txRptr_q, txCount;
    logic [7:0]   rxMem [RX_DEPTH];
    logic [RXW:0] rxWptr_q, rxRptr_q, rxCount;

    logic [1:0]   ctrl_q;
    logic         loopback;
    logic         rxOvf_q, txOvf_q, break_q;
    logic [31:0]  rdata_q, rdMux, statusWord;
    logic         irq_q;

    logic hit, wrAcc, rdAcc, wrData, wrCtrl, rdData;
    logic txEmpty, txFull, txPush, txPop;
    logic rxEmpty, rxFull, rxPush, rxPop, rxPushReq, lbPush;
    logic [7:0] rxIn, txCnt8, rxCnt8;
    logic unusedWdata;

    // A read strobe is ignored whenever a write is presented in the same cycle.
    assign hit    = (bus_addr[63:4] == BASE_ADDR[63:4]);
    assign wrAcc  = hit & bus_wen;
    assign rdAcc  = hit & bus_ren & ~bus_wen;
    assign wrData = wrAcc & (bus_addr[3:0] == 4'h0);
    assign wrCtrl = wrAcc & (bus_addr[3:0] == 4'h8);
    assign rdData = rdAcc & (bus_addr[3:0] == 4'h0);

    assign txCount = txWptr_q - txRptr_q;
    assign txEmpty = (txWptr_q == txRptr_q);
    assign txFull  = (txWptr_q[TXW] != txRptr_q[TXW]) && (txWptr_q[TXW-1:0] == txRptr_q[TXW-1:0]);
    assign txPop   = (state_q == IDLE) && !txEmpty && !tx_busy;
    assign txPush  = wrData && (!txFull || txPop);

    // In LOAD a cleared tx_en marks a byte taken for loopback rather than for uart_tx.
    assign lbPush    = (state_q == LOAD) && !txEn_q;
    assign rxPushReq = lbPush || (rx_valid && !loopback);
    assign rxIn      = lbPush ? txData_q : rx_data;
    assign rxCount   = rxWptr_q - rxRptr_q;
    assign rxEmpty   = (rxWptr_q == rxRptr_q);
    assign rxFull    = (rxWptr_q[RXW] != rxRptr_q[RXW]) && (rxWptr_q[RXW-1:0] == rxRptr_q[RXW-1:0]);
    assign rxPop     = rdData && !rxEmpty;
    assign rxPush    = rxPushReq && (!rxFull || rxPop);

    assign txCnt8     = 8'(txCount);
    assign rxCnt8     = 8'(rxCount);
    assign statusWord = {8'h00, txCnt8, rxCnt8, 1'b0, break_q, txOvf_q, rxOvf_q,
                         txEmpty && (state_q == IDLE), txEmpty, txFull, !rxEmpty};

    assign unusedWdata = ^bus_wdata[30:2];

`ifdef UART_LOOPBACK_EN
    logic lbEn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         lbEn_q <= 1'b0;
        else if (wrCtrl) lbEn_q <= bus_wdata[2];
    end

    assign loopback = lbEn_q;
`else
    assign loopback = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txWptr_q <= '0;
            txRptr_q <= '0;
            rxWptr_q <= '0;
            rxRptr_q <= '0;
        end else begin
            if (txPush) txWptr_q <= txWptr_q + (TXW+1)'(1);
            if (txPop)  txRptr_q <= txRptr_q + (TXW+1)'(1);
            if (rxPush) rxWptr_q <= rxWptr_q + (RXW+1)'(1);
            if (rxPop)  rxRptr_q <= rxRptr_q + (RXW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (txPush) txMem[txWptr_q[TXW-1:0]] <= bus_wdata[7:0];
        if (rxPush) rxMem[rxWptr_q[RXW-1:0]] <= rxIn;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            txData_q  <= '0;
            txEn_q    <= 1'b0;
            waitCnt_q <= '0;
        end else begin
            txEn_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (txPop) begin
                        state_q  <= LOAD;
                        txData_q <= txMem[txRptr_q[TXW-1:0]];
                        txEn_q   <= !loopback;
                    end
                end
                LOAD: begin
                    waitCnt_q <= '0;
                    state_q   <= txEn_q ? WAIT_BUSY : IDLE;
                end
                // A uart_tx that never raises busy is treated as having sent the byte.
                WAIT_BUSY: begin
                    if (tx_busy)                 state_q   <= WAIT_DONE;
                    else if (waitCnt_q == 2'd3)  state_q   <= IDLE;
                    else                         waitCnt_q <= waitCnt_q + 2'd1;
                end
                WAIT_DONE: begin
                    if (!tx_busy) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        rdMux = '0;
        case (bus_addr[3:0])
            4'h0:    if (!rxEmpty) rdMux = {24'h0, rxMem[rxRptr_q[RXW-1:0]]};
            4'h4:    rdMux = statusWord;
            4'h8:    rdMux = {29'h0, loopback, ctrl_q};
            default: rdMux = '0;
        endcase
    end

    // Sticky sets are placed after the clear so a same-cycle event is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= '0;
            rxOvf_q <= 1'b0;
            txOvf_q <= 1'b0;
            break_q <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            if (wrCtrl) begin
                ctrl_q <= bus_wdata[1:0];
                if (bus_wdata[31]) begin
                    rxOvf_q <= 1'b0;
                    txOvf_q <= 1'b0;
                    break_q <= 1'b0;
                end
            end
            if (rxPushReq && rxFull && !rxPop) rxOvf_q <= 1'b1;
            if (wrData && txFull && !txPop)    txOvf_q <= 1'b1;
            if (rx_break)                      break_q <= 1'b1;
            if (rdAcc)                         rdata_q <= rdMux;
            irq_q <= (ctrl_q[0] & !rxEmpty) | (ctrl_q[1] & txEmpty);
        end
    end

    assign bus_rdata = rdata_q;
    assign tx_data   = txData_q;
    assign tx_en     = txEn_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Randomized bench for uart_mmio_ctrl: queue-based model of both FIFOs and the sticky flags,
// plus a simple uart_tx busy model that scoreboards every tx_en pulse.
module tb_uart_mmio_ctrl;
    localparam int          TX_DEPTH = 8;
    localparam int          RX_DEPTH = 8;
    localparam logic [63:0] BASE     = 64'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] bus_addr = BASE;
    logic        bus_wen = 1'b0;
    logic        bus_ren = 1'b0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_busy = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_break = 1'b0;
    logic        irq;

    uart_mmio_ctrl #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_ren(bus_ren),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .tx_data(tx_data), .tx_en(tx_en),
        .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid), .rx_break(rx_break), .irq(irq)
    );

    always #5 clk = ~clk;

    int          checkCount = 0;
    int          errorCount = 0;
    logic [7:0]  expTx[$];
    logic [7:0]  rxQ[$];
    bit          mRxOvf, mTxOvf, mBreak;
    logic [31:0] mCtrl = '0;
    logic [31:0] lastRd = '0;
    bit          forceBusy = 1'b0;
    bit          noBusy = 1'b0;
    int          busyLen = 20;
    int          busyLeft = 0;
    int          sinceLast = 100;
    logic [7:0]  expByte;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    // uart_tx stand-in: busy for busyLen cycles after each tx_en, or held/never raised on request.
    always @(negedge clk) begin
        sinceLast++;
        if (tx_en === 1'b1) begin
            checkOutput("tx_en_while_busy", 32'(tx_busy), 32'd0);
            checkOutput("tx_en_gap", 32'(sinceLast >= 2), 32'd1);
            sinceLast = 0;
            checkOutput("tx_pulse_expected", 32'(expTx.size() != 0), 32'd1);
            if (expTx.size() != 0) begin
                expByte = expTx.pop_front();
                checkOutput("tx_data", {24'h0, tx_data}, {24'h0, expByte});
            end
            if (!noBusy) busyLeft = busyLen;
        end
        if (forceBusy) tx_busy = 1'b1;
        else if (busyLeft > 0) begin
            tx_busy = 1'b1;
            busyLeft--;
        end else tx_busy = 1'b0;
    end

    function automatic logic [31:0] expStatus(input bit txIdle, input int txCnt);
        logic [31:0] s = '0;
        s[0]     = rxQ.size() != 0;
        s[1]     = txCnt == TX_DEPTH;
        s[2]     = txCnt == 0;
        s[3]     = txIdle;
        s[4]     = mRxOvf;
        s[5]     = mTxOvf;
        s[6]     = mBreak;
        s[15:8]  = 8'(rxQ.size());
        s[23:16] = 8'(txCnt);
        return s;
    endfunction

    task automatic pushRxModel(input logic [7:0] b);
        if (rxQ.size() < RX_DEPTH) rxQ.push_back(b);
        else mRxOvf = 1'b1;
    endtask

    task automatic applyStimulus(input bit wen, input bit ren, input logic [3:0] off, input logic [31:0] wdata);
        @(negedge clk);
        bus_addr  = BASE | {60'h0, off};
        bus_wen   = wen;
        bus_ren   = ren;
        bus_wdata = wdata;
        @(negedge clk);
        bus_wen = 1'b0;
        bus_ren = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [3:0] off, input logic [31:0] expected);
        applyStimulus(1'b0, 1'b1, off, 32'h0);
        checkOutput(tag, bus_rdata, expected);
        lastRd = expected;
    endtask

    task automatic readData(input string tag);
        logic [31:0] e;
        e = (rxQ.size() != 0) ? {24'h0, rxQ.pop_front()} : 32'h0;
        readCheck(tag, 4'h0, e);
    endtask

    task automatic writeCtrl(input logic [31:0] v);
        applyStimulus(1'b1, 1'b0, 4'h8, v);
`ifdef UART_LOOPBACK_EN
        mCtrl = {29'h0, v[2:0]};
`else
        mCtrl = {30'h0, v[1:0]};
`endif
        if (v[31]) begin
            mRxOvf = 1'b0;
            mTxOvf = 1'b0;
            mBreak = 1'b0;
        end
    endtask

    task automatic injectRx(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic rxPushPop(input logic [7:0] b);
        logic [31:0] e;
        e = (rxQ.size() != 0) ? {24'h0, rxQ.pop_front()} : 32'h0;
        pushRxModel(b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        bus_addr = BASE;
        bus_ren  = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        bus_ren  = 1'b0;
        checkOutput("rx_pushpop_rd", bus_rdata, e);
        lastRd = e;
    endtask

    task automatic waitDrain(input int limit);
        int n = 0;
        while ((expTx.size() != 0 || tx_busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput("tx_drain_left", 32'(expTx.size()), 32'd0);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errorCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int op;

        repeat (3) @(negedge clk);
        checkOutput("rst_rdata", bus_rdata, 32'h0);
        checkOutput("rst_tx_en", 32'(tx_en), 32'h0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'h0);
        checkOutput("rst_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        readCheck("rst_status", 4'h4, expStatus(1'b1, 0));
        readCheck("rst_ctrl", 4'h8, 32'h0);
        readCheck("unmapped_rd", 4'hC, 32'h0);

        $display("[TB] two-byte transmit plus random bytes");
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h41); expTx.push_back(8'h41);
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h42); expTx.push_back(8'h42);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            applyStimulus(1'b1, 1'b0, 4'h0, {24'h0, b});
            expTx.push_back(b);
        end
        waitDrain(1000);
        readCheck("tx_idle_status", 4'h4, expStatus(1'b1, 0));

        $display("[TB] uart_tx that never raises busy");
        noBusy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            applyStimulus(1'b1, 1'b0, 4'h0, {24'h0, b});
            expTx.push_back(b);
        end
        waitDrain(300);
        noBusy = 1'b0;

        $display("[TB] TX overflow with busy held");
        forceBusy = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < TX_DEPTH + 1; i++) begin
            b = 8'($urandom);
            applyStimulus(1'b1, 1'b0, 4'h0, {24'h0, b});
            if (i < TX_DEPTH) expTx.push_back(b);
            else mTxOvf = 1'b1;
        end
        readCheck("tx_full_status", 4'h4, expStatus(1'b0, TX_DEPTH));
        writeCtrl(32'h8000_0000);
        readCheck("tx_ovf_cleared", 4'h4, expStatus(1'b0, TX_DEPTH));
        forceBusy = 1'b0;
        waitDrain(2000);
        readCheck("tx_drained_status", 4'h4, expStatus(1'b1, 0));

        $display("[TB] RX capture and reads");
        injectRx(8'h55); pushRxModel(8'h55);
        injectRx(8'hAA); pushRxModel(8'hAA);
        readData("rx_rd_first");
        readData("rx_rd_second");
        readCheck("rx_empty_status", 4'h4, expStatus(1'b1, 0));
        readData("rx_rd_empty");

        b = 8'($urandom);
        injectRx(8'h3C); pushRxModel(8'h3C);
        applyStimulus(1'b1, 1'b1, 4'h0, {24'h0, b});
        expTx.push_back(b);
        checkOutput("wen_ren_rdata_hold", bus_rdata, lastRd);
        readData("wen_ren_no_pop");
        waitDrain(1000);

        $display("[TB] RX overflow and simultaneous push/pop when full");
        for (int i = 0; i < RX_DEPTH + 1; i++) begin
            b = 8'($urandom);
            injectRx(b);
            pushRxModel(b);
        end
        readCheck("rx_ovf_status", 4'h4, expStatus(1'b1, 0));
        writeCtrl(32'h8000_0000);
        rxPushPop(8'($urandom));
        readCheck("rx_full_pushpop_status", 4'h4, expStatus(1'b1, 0));
        for (int i = 0; i < RX_DEPTH; i++) readData("rx_drain");
        @(negedge clk); rx_break = 1'b1;
        @(negedge clk); rx_break = 1'b0; mBreak = 1'b1;
        readCheck("break_status", 4'h4, expStatus(1'b1, 0));
        writeCtrl(32'h8000_0000);

        $display("[TB] interrupts");
        writeCtrl(32'h1);
        injectRx(8'h5A); pushRxModel(8'h5A);
        checkOutput("irq_before_reg", 32'(irq), 32'd0);
        @(negedge clk);
        checkOutput("irq_rise", 32'(irq), 32'd1);
        readData("irq_rx_pop");
        checkOutput("irq_hold_after_pop", 32'(irq), 32'd1);
        @(negedge clk);
        checkOutput("irq_fall", 32'(irq), 32'd0);
        writeCtrl(32'h2);
        @(negedge clk);
        checkOutput("irq_tx_empty", 32'(irq), 32'd1);
        writeCtrl(32'h0);
        @(negedge clk);
        checkOutput("irq_disabled", 32'(irq), 32'd0);

        $display("[TB] randomized RX traffic");
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 4);
            b  = 8'($urandom);
            case (op)
                0, 1: begin injectRx(b); pushRxModel(b); end
                2:    readData("rand_rd");
                3:    readCheck("rand_status", 4'h4, expStatus(1'b1, 0));
                default: rxPushPop(b);
            endcase
        end
        while (rxQ.size() != 0) readData("rand_drain");
        writeCtrl(32'h8000_0000);

        $display("[TB] reset in WAIT_DONE with bytes queued");
        busyLen = 60;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            applyStimulus(1'b1, 1'b0, 4'h0, {24'h0, b});
            expTx.push_back(b);
        end
        writeCtrl(32'h1);
        b = 8'($urandom);
        injectRx(b); pushRxModel(b);
        readCheck("pre_reset_status", 4'h4, expStatus(1'b0, 3));
        checkOutput("pre_reset_irq", 32'(irq), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_reset_tx_en", 32'(tx_en), 32'd0);
        checkOutput("mid_reset_irq", 32'(irq), 32'd0);
        checkOutput("mid_reset_rdata", bus_rdata, 32'd0);
        expTx.delete();
        rxQ.delete();
        mRxOvf = 1'b0; mTxOvf = 1'b0; mBreak = 1'b0; mCtrl = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        readCheck("post_reset_status", 4'h4, expStatus(1'b1, 0));
        readCheck("post_reset_ctrl", 4'h8, mCtrl);
        checkOutput("post_reset_irq", 32'(irq), 32'd0);
        busyLen = 20;
        waitDrain(200);

`ifdef UART_LOOPBACK_EN
        $display("[TB] loopback");
        writeCtrl(32'h4);
        readCheck("lb_ctrl", 4'h8, mCtrl);
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h7E);
        repeat (10) @(negedge clk);
        pushRxModel(8'h7E);
        readData("lb_rd");
        injectRx(8'h11);
        readData("lb_ext_ignored");
        writeCtrl(32'h0);
`else
        applyStimulus(1'b1, 1'b0, 4'h8, 32'h4);
        readCheck("no_lb_ctrl", 4'h8, 32'h0);
`endif

        repeat (10) @(negedge clk);
        checkOutput("tx_leftover", 32'(expTx.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
- Memory-mapped controller between the CPU data bus and the uart_tx/uart_rx cores.
- Buffers outgoing bytes in a TX FIFO and sequences the uart_tx en/busy handshake one byte at a time.
- Captures uart_rx bytes into an RX FIFO.
- Exposes DATA/STATUS/CTRL registers and a level interrupt.

Parameters:
- TX_DEPTH, 8, TX FIFO entries; power of 2, ≥2.
- RX_DEPTH, 8, RX FIFO entries; power of 2, ≥2.
- BASE_ADDR, 64'h1000_0000, bus base address; bits [63:4] must match for a register hit.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- bus_addr  in  64  CPU byte address
- bus_wen  in  1  write strobe, one cycle per access
- bus_ren  in  1  read strobe, one cycle per access
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data, registered
- tx_data  out  8  byte to uart_tx
- tx_en  out  1  one-cycle start pulse to uart_tx
- tx_busy  in  1  uart_tx busy
- rx_data  in  8  byte from uart_rx
- rx_valid  in  1  one-cycle valid from uart_rx
- rx_break  in  1  break detected
- irq  out  1  level interrupt

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high.
- Reset values: bus_rdata=0, tx_data=0, tx_en=0, irq=0, both FIFOs empty, CTRL=0, sticky flags=0, TX FSM=IDLE.
- Register map (offset = bus_addr[3:0]; other offsets read 0, writes ignored):
  - 0x0 DATA
    - Write: push bus_wdata[7:0] to TX FIFO. If full, drop the byte and set TX_OVF.
    - Read: pop RX FIFO and return {24'b0, byte}. If empty, return 0 with no pop.
  - 0x4 STATUS (read-only)
    - [0] RX_NE, [1] TX_FULL, [2] TX_EMPTY, [3] TX_IDLE (FIFO empty and FSM IDLE), [4] RX_OVF, [5] TX_OVF, [6] BREAK.
    - [15:8] RX count, [23:16] TX count.
  - 0x8 CTRL (R/W)
    - [0] RX_IE, [1] TX_IE, [2] LOOPBACK (only with macro).
    - A write to 0x8 with wdata[31]=1 clears RX_OVF, TX_OVF and BREAK.
- Read latency: bus_rdata updates on the clock edge after bus_ren and holds until the next read.
- bus_wen and bus_ren both high: write wins, no read side effects.
- RX capture: each rx_valid pushes rx_data.
  - RX FIFO full: byte dropped, RX_OVF set.
  - Push and pop in the same cycle when full: pop then push succeed, no overflow.
  - rx_break=1 sets BREAK sticky.
- TX FSM:
  - IDLE: if FIFO not empty and tx_busy=0 → LOAD; tx_data <= FIFO head; pop.
  - LOAD: tx_en=1 for exactly one cycle → WAIT_BUSY.
  - WAIT_BUSY: tx_busy=1 → WAIT_DONE. If no rise within 4 cycles → IDLE (byte considered sent).
  - WAIT_DONE: tx_busy=0 → IDLE.
  - Minimum 2 cycles between consecutive tx_en pulses; tx_en is never asserted while tx_busy=1.
  - Simultaneous bus push and FSM pop on a full FIFO: both succeed.
- Pointer rules: FIFO pointers are log2(DEPTH)+1 bits wide and wrap naturally; full = MSBs differ and LSBs equal.
- irq = (RX_IE & RX_NE) | (TX_IE & TX_EMPTY), registered (1 cycle after the condition).
- Reset mid-byte: FSM returns to IDLE immediately; tx_en deasserts; queued bytes are lost; uart_tx finishes its current frame independently.

Optional Feature:
- Macro UART_LOOPBACK_EN.
- Defined:
  - CTRL[2]=1 routes TX FSM output into the RX FIFO instead of pulsing tx_en.
  - LOAD pushes tx_data into RX (overflow rules apply), then returns directly to IDLE.
  - External rx_valid is ignored while LOOPBACK=1.
- Undefined: CTRL[2] reads 0, writes ignored; no loopback logic present.

Test Plan:
1. Write 0x41, 0x42 to DATA; model uart_tx busy for 20 cycles per byte → tx_en pulses twice with tx_data 0x41 then 0x42; second pulse only after busy falls; TX_IDLE=1 at end.
2. Nine DATA writes with tx_busy held high → first eight queued; ninth dropped; STATUS TX_FULL=1, TX_OVF=1; CTRL write 0x8000_0000 clears TX_OVF.
3. Inject rx_valid with 0x55, 0xAA; read DATA twice → bus_rdata 0x55 then 0xAA, one cycle after each ren; STATUS RX_NE=0 afterwards; a third read returns 0.
4. Set CTRL=0x1; inject one RX byte → irq rises 1 cycle after the push and falls 1 cycle after the pop.
5. Assert rst during WAIT_DONE with 3 bytes queued → tx_en=0, STATUS reads TX_EMPTY=1 and TX_IDLE=1, CTRL=0, irq=0.
6. (UART_LOOPBACK_EN) CTRL=0x4; write 0x7E → no tx_en; DATA read returns 0x7E.
